// File: rtl/matrix_mac_sequencer.sv
// Sequencer for the 4x4 matrix MAC datapath: buffers A/B row pairs, issues a clear and four
// rank-1 steps to the MAC array, then streams the accumulated 4x4 result out row by row.
module matrix_mac_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int MAC_LATENCY = 1
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_accum_i,
    input  logic [4*DATA_WIDTH-1:0]  in_a_row_i,
    input  logic [4*DATA_WIDTH-1:0]  in_b_row_i,
    output logic                     mac_clear_o,
    output logic                     mac_enable_o,
    output logic [4*DATA_WIDTH-1:0]  mac_a_col_o,
    output logic [4*DATA_WIDTH-1:0]  mac_b_row_o,
    input  logic [16*ACC_WIDTH-1:0]  mac_result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [4*ACC_WIDTH-1:0]   out_row_o,
    output logic [1:0]               out_row_idx_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        COMPUTE,
        WAIT,
        DRAIN
    } state_e;

    localparam int WaitW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAC_LATENCY - 1);

    state_e                  state_q;
    logic [1:0]              row_q;
    logic [1:0]              k_q;
    logic [1:0]              r_q;
    logic [WaitW-1:0]        wait_q;
    logic                    accum_q;
    logic                    in_ready_q;
    logic                    mac_clear_q;
    logic                    mac_enable_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   a_buf_q [4][4];
    logic [DATA_WIDTH-1:0]   b_buf_q [4][4];
    logic [4*ACC_WIDTH-1:0]  result_rows [4];
    logic                    beat;

    assign beat = in_valid_i & in_ready_q;

    // Operand buffers hold their contents across reset; every job rewrites all four rows.
    always_ff @(posedge clock_i) begin
        if (beat) begin
            for (int j = 0; j < 4; j++) begin
                a_buf_q[row_q][j] <= in_a_row_i[j*DATA_WIDTH +: DATA_WIDTH];
                b_buf_q[row_q][j] <= in_b_row_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            row_q        <= 2'd0;
            k_q          <= 2'd0;
            r_q          <= 2'd0;
            wait_q       <= '0;
            accum_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            mac_clear_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        accum_q <= in_accum_i;
                        row_q   <= 2'd1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (row_q == 2'd3) begin
                            row_q      <= 2'd0;
                            in_ready_q <= 1'b0;
                            if (accum_q) begin
                                k_q          <= 2'd0;
                                mac_enable_q <= 1'b1;
                                state_q      <= COMPUTE;
                            end else begin
                                mac_clear_q <= 1'b1;
                                state_q     <= CLEAR;
                            end
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                end
                CLEAR: begin
                    mac_clear_q  <= 1'b0;
                    mac_enable_q <= 1'b1;
                    k_q          <= 2'd0;
                    state_q      <= COMPUTE;
                end
                COMPUTE: begin
                    if (k_q == 2'd3) begin
                        k_q          <= 2'd0;
                        mac_enable_q <= 1'b0;
                        wait_q       <= '0;
                        state_q      <= WAIT;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                // The MAC array needs MAC_LATENCY cycles after its last step before the sum is usable.
                WAIT: begin
                    if (wait_q == WaitLast) begin
                        wait_q      <= '0;
                        r_q         <= 2'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= DRAIN;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (r_q == 2'd3) begin
                            r_q         <= 2'd0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            r_q <= r_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    in_ready_q   <= 1'b1;
                    mac_clear_q  <= 1'b0;
                    mac_enable_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // Column k of A and row k of B, zeroed whenever no MAC step is being issued.
    always_comb begin
        mac_a_col_o = '0;
        mac_b_row_o = '0;
        if (mac_enable_q) begin
            for (int i = 0; i < 4; i++) begin
                mac_a_col_o[i*DATA_WIDTH +: DATA_WIDTH] = a_buf_q[i][k_q];
                mac_b_row_o[i*DATA_WIDTH +: DATA_WIDTH] = b_buf_q[k_q][i];
            end
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_rows
        assign result_rows[r] = mac_result_i[r*4*ACC_WIDTH +: 4*ACC_WIDTH];
    end

    assign out_row_o     = out_valid_q ? result_rows[r_q] : '0;
    assign out_row_idx_o = r_q;
    assign out_valid_o   = out_valid_q;
    assign in_ready_o    = in_ready_q;
    assign mac_clear_o   = mac_clear_q;
    assign mac_enable_o  = mac_enable_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: a behavioural MAC array feeds the DUT, and a matrix-product
// reference model predicts every MAC step, result row, clear count and job duration.
module tb_matrix_mac_sequencer;
    localparam int DW = 8;
    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic            inValid, inReady, inAccum;
    logic [4*DW-1:0] inARow, inBRow;
    logic            macClear, macEnable;
    logic [4*DW-1:0] macACol, macBRow;
    logic [16*AW-1:0] macResult;
    logic            outValid, outReady;
    logic [4*AW-1:0] outRow;
    logic [1:0]      outRowIdx;
    logic            busy, done;

    logic            inValid3, inReady3, inAccum3;
    logic [4*DW-1:0] inARow3, inBRow3;
    logic            macClear3, macEnable3;
    logic [4*DW-1:0] macACol3, macBRow3;
    logic [16*AW-1:0] macResult3;
    logic            outValid3, outReady3;
    logic [4*AW-1:0] outRow3;
    logic [1:0]      outRowIdx3;
    logic            busy3, done3;

    matrix_mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAC_LATENCY(1)) dut (
        .clock_i(clock), .reset_i(reset),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_accum_i(inAccum),
        .in_a_row_i(inARow), .in_b_row_i(inBRow),
        .mac_clear_o(macClear), .mac_enable_o(macEnable),
        .mac_a_col_o(macACol), .mac_b_row_o(macBRow), .mac_result_i(macResult),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .out_row_o(outRow), .out_row_idx_o(outRowIdx),
        .busy_o(busy), .done_o(done)
    );

    matrix_mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAC_LATENCY(3)) dut3 (
        .clock_i(clock), .reset_i(reset),
        .in_valid_i(inValid3), .in_ready_o(inReady3), .in_accum_i(inAccum3),
        .in_a_row_i(inARow3), .in_b_row_i(inBRow3),
        .mac_clear_o(macClear3), .mac_enable_o(macEnable3),
        .mac_a_col_o(macACol3), .mac_b_row_o(macBRow3), .mac_result_i(macResult3),
        .out_valid_o(outValid3), .out_ready_i(outReady3),
        .out_row_o(outRow3), .out_row_idx_o(outRowIdx3),
        .busy_o(busy3), .done_o(done3)
    );

    // Behavioural MAC arrays: latency 1 (direct accumulator) and latency 3 (two extra stages).
    logic [AW-1:0] acc1 [16];
    logic [AW-1:0] acc3 [16];
    logic [AW-1:0] pipeA3 [16];
    logic [AW-1:0] pipeB3 [16];

    always @(posedge clock) begin
        if (macClear) begin
            for (int i = 0; i < 16; i++) acc1[i] <= '0;
        end else if (macEnable) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    acc1[r*4+c] <= acc1[r*4+c] + AW'(macACol[r*DW +: DW]) * AW'(macBRow[c*DW +: DW]);
        end
        if (macClear3) begin
            for (int i = 0; i < 16; i++) acc3[i] <= '0;
        end else if (macEnable3) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    acc3[r*4+c] <= acc3[r*4+c] + AW'(macACol3[r*DW +: DW]) * AW'(macBRow3[c*DW +: DW]);
        end
        pipeA3 <= acc3;
        pipeB3 <= pipeA3;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            macResult[i*AW +: AW]  = acc1[i];
            macResult3[i*AW +: AW] = pipeB3[i];
        end
    end

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] curA [4][4];
    logic [DW-1:0] curB [4][4];
    logic [DW-1:0] curA3 [4][4];
    logic [DW-1:0] curB3 [4][4];
    logic [AW-1:0] expRes [4][4];
    logic [AW-1:0] modelAcc [4][4];
    logic [4*DW-1:0] expCol, expRow;

    int cyc = 0;
    int enSeen = 0, clrSeen = 0, rowSeen = 0, doneSeen = 0, doneCyc = 0;
    int stallRow = -1, stallLeft = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Per-cycle monitor: checks MAC operands and result rows, and drives out_ready stalls.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            outReady = 1'b1;
        end else begin
            if (macEnable) begin
                for (int i = 0; i < 4; i++) begin
                    expCol[i*DW +: DW] = curA[i][enSeen % 4];
                    expRow[i*DW +: DW] = curB[enSeen % 4][i];
                end
                checkOutput("macACol", 64'(macACol), 64'(expCol));
                checkOutput("macBRow", 64'(macBRow), 64'(expRow));
            end else begin
                checkOutput("macOperandsZero", 64'({macACol, macBRow}), 64'(0));
            end
            if (macClear || macEnable || outValid) begin
                checkOutput("inReadyLowWhenBusy", 64'(inReady), 64'(0));
                checkOutput("busyHigh", 64'(busy), 64'(1));
            end
            if (outValid) begin
                checkOutput("outRowIdx", 64'(outRowIdx), 64'(rowSeen % 4));
                for (int c = 0; c < 4; c++)
                    checkOutput("outRow", 64'(outRow[c*AW +: AW]), 64'(expRes[rowSeen % 4][c]));
            end else begin
                checkOutput("outRowZero", 64'(outRow != '0), 64'(0));
            end
            if (outValid && int'(outRowIdx) == stallRow && stallLeft > 0) begin
                outReady = 1'b0;
                stallLeft--;
            end else begin
                outReady = 1'b1;
            end
            if (outValid && outReady) rowSeen++;
            if (macClear) clrSeen++;
            if (macEnable) enSeen++;
            if (done) begin
                doneSeen++;
                doneCyc = cyc;
            end
        end
    end

    task automatic randomMatrices();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                curA[i][j] = DW'($urandom);
                curB[i][j] = DW'($urandom);
            end
    endtask

    // Reference: result = A*B, or previous accumulator + A*B when the job keeps the accumulator.
    task automatic computeExpected(input bit accum);
        logic [AW-1:0] s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = '0;
                for (int k = 0; k < 4; k++) s += AW'(curA[r][k]) * AW'(curB[k][c]);
                expRes[r][c] = accum ? modelAcc[r][c] + s : s;
                modelAcc[r][c] = expRes[r][c];
            end
    endtask

    task automatic applyStimulus(input bit accum, input int gap, input bit abortAtK2,
                                 input int stallR, input int stallN);
        int beatCyc, waitCnt, expCycles;
        computeExpected(accum);
        enSeen = 0; clrSeen = 0; rowSeen = 0; doneSeen = 0; beatCyc = 0;
        stallRow = stallR; stallLeft = stallN;
        expCycles = 14 - int'(accum) + gap + stallN;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                repeat (gap) begin
                    inValid = 1'b0;
                    @(negedge clock); #1;
                end
            end
            inValid = 1'b1;
            inAccum = (i == 0) ? accum : 1'($urandom);
            for (int j = 0; j < 4; j++) begin
                inARow[j*DW +: DW] = curA[i][j];
                inBRow[j*DW +: DW] = curB[i][j];
            end
            waitCnt = 0;
            while (!inReady && waitCnt < 50) begin
                @(negedge clock); #1;
                waitCnt++;
            end
            checkOutput("inReadyLoad", 64'(inReady), 64'(1));
            if (i == 0) beatCyc = cyc;
            if (i == 3) checkOutput("noMacBeforeRow3", 64'(enSeen + clrSeen), 64'(0));
            @(negedge clock); #1;
        end
        inValid = 1'b0;
        inAccum = 1'($urandom);
        if (abortAtK2) begin
            waitCnt = 0;
            while (!(macEnable && enSeen == 3) && waitCnt < 50) begin
                @(negedge clock); #1;
                waitCnt++;
            end
            checkOutput("reachK2", 64'(enSeen), 64'(3));
            reset = 1'b1;
            @(negedge clock); #1;
            checkOutput("abortMacEnable", 64'(macEnable), 64'(0));
            checkOutput("abortBusy", 64'(busy), 64'(0));
            checkOutput("abortInReady", 64'(inReady), 64'(1));
            checkOutput("abortOutValid", 64'(outValid), 64'(0));
            checkOutput("abortDone", 64'(done), 64'(0));
            reset = 1'b0;
            repeat (20) @(negedge clock);
            #1;
            checkOutput("abortNoDone", 64'(doneSeen), 64'(0));
            return;
        end
        waitCnt = 0;
        while (doneSeen == 0 && waitCnt < 200) begin
            @(negedge clock); #1;
            waitCnt++;
        end
        checkOutput("doneSeen", 64'(doneSeen), 64'(1));
        checkOutput("jobCycles", 64'(doneCyc - beatCyc), 64'(expCycles));
        checkOutput("clearCount", 64'(clrSeen), 64'(accum ? 0 : 1));
        checkOutput("enableCount", 64'(enSeen), 64'(4));
        checkOutput("rowsAccepted", 64'(rowSeen), 64'(4));
        @(negedge clock); #1;
        checkOutput("donePulseWidth", 64'(done), 64'(0));
        checkOutput("doneOnce", 64'(doneSeen), 64'(1));
    endtask

    task automatic runLatency3();
        int waitCnt, gapCnt;
        logic [AW-1:0] e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                curA3[i][j] = DW'($urandom);
                curB3[i][j] = DW'($urandom);
            end
        for (int i = 0; i < 4; i++) begin
            inValid3 = 1'b1;
            inAccum3 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                inARow3[j*DW +: DW] = curA3[i][j];
                inBRow3[j*DW +: DW] = curB3[i][j];
            end
            checkOutput("lat3InReady", 64'(inReady3), 64'(1));
            @(negedge clock); #1;
        end
        inValid3 = 1'b0;
        waitCnt = 0;
        while (!macEnable3 && waitCnt < 20) begin
            @(negedge clock); #1;
            waitCnt++;
        end
        waitCnt = 0;
        while (macEnable3 && waitCnt < 10) begin
            @(negedge clock); #1;
            waitCnt++;
        end
        checkOutput("lat3EnableCycles", 64'(waitCnt), 64'(4));
        gapCnt = 0;
        while (!outValid3 && gapCnt < 20) begin
            @(negedge clock); #1;
            gapCnt++;
        end
        checkOutput("lat3WaitCycles", 64'(gapCnt), 64'(3));
        for (int r = 0; r < 4; r++) begin
            checkOutput("lat3OutValid", 64'(outValid3), 64'(1));
            checkOutput("lat3RowIdx", 64'(outRowIdx3), 64'(r));
            for (int c = 0; c < 4; c++) begin
                e = '0;
                for (int k = 0; k < 4; k++) e += AW'(curA3[r][k]) * AW'(curB3[k][c]);
                checkOutput("lat3OutRow", 64'(outRow3[c*AW +: AW]), 64'(e));
            end
            @(negedge clock); #1;
        end
        checkOutput("lat3Done", 64'(done3), 64'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        inValid = 1'b0; inAccum = 1'b0; inARow = '0; inBRow = '0;
        inValid3 = 1'b0; inAccum3 = 1'b0; inARow3 = '0; inBRow3 = '0;
        outReady = 1'b1; outReady3 = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("resetInReady", 64'(inReady), 64'(1));
        checkOutput("resetBusy", 64'(busy), 64'(0));
        checkOutput("resetDone", 64'(done), 64'(0));
        checkOutput("resetOutValid", 64'(outValid), 64'(0));
        checkOutput("resetMacStrobes", 64'({macClear, macEnable}), 64'(0));
        checkOutput("resetOutRowIdx", 64'(outRowIdx), 64'(0));
        checkOutput("resetBusy3", 64'(busy3), 64'(0));
        reset = 1'b0;
        @(negedge clock); #1;

        $display("[TB] identity A, counting B");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                curA[i][j] = (i == j) ? 8'd1 : 8'd0;
                curB[i][j] = DW'(4*i + j);
            end
        applyStimulus(1'b0, 0, 1'b0, -1, 0);

        $display("[TB] same job accumulated");
        applyStimulus(1'b1, 0, 1'b0, -1, 0);

        $display("[TB] input gap between beats 1 and 2");
        randomMatrices();
        applyStimulus(1'b0, 3, 1'b0, -1, 0);

        $display("[TB] output stall on row 1");
        randomMatrices();
        applyStimulus(1'b0, 0, 1'b0, 1, 5);

        $display("[TB] reset during compute");
        randomMatrices();
        applyStimulus(1'b0, 0, 1'b1, -1, 0);
        randomMatrices();
        applyStimulus(1'b0, 0, 1'b0, -1, 0);

        $display("[TB] randomized jobs");
        for (int n = 0; n < 8; n++) begin
            randomMatrices();
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] MAC_LATENCY=3 instance");
        runLatency3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
